// File: rtl/core_sync_pkg.sv
// Shared types and constants for the multicore run sequencer.
package core_sync_pkg;

  localparam int MAX_CORES = 16;

  typedef logic [MAX_CORES-1:0] core_mask_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } sync_state_e;

endpackage

// File: rtl/core_popcount.sv
// Combinational population count of an N-bit vector; zero latency, no flow control.
module core_popcount #(
  parameter int N     = 16,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     vec,
  output logic [CNT_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/core_sync_ctrl.sv
// Launches one run on the masked cores, gathers done, reports completion and run length.
// core_start 1 cycle after accept, all_done 1 cycle after last done; start outside IDLE is dropped.
// Optional run timeout built when CORE_SYNC_TIMEOUT_EN is defined.
module core_sync_ctrl
  import core_sync_pkg::*;
#(
  parameter int NUM_CORES   = 16,
  parameter int CYC_W       = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_CORES-1:0]           core_en,
  input  logic [NUM_CORES-1:0]           core_done,
  output logic [NUM_CORES-1:0]           core_start,
  output logic                           busy,
  output logic                           all_done,
  output logic                           start_err,
  output logic [$clog2(NUM_CORES+1)-1:0] active_cnt,
  output logic [CYC_W-1:0]               cycle_cnt,
  output logic                           timeout
);

  localparam int CNT_W = $clog2(NUM_CORES + 1);

  sync_state_e          state_q, state_d;
  logic [NUM_CORES-1:0] en_q, en_d;
  logic [NUM_CORES-1:0] done_seen_q, done_seen_d;
  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic                 busy_q, busy_d;
  logic                 all_done_q, all_done_d;
  logic                 start_err_q, start_err_d;
  logic [CNT_W-1:0]     active_cnt_q, active_cnt_d;
  logic [CYC_W-1:0]     cycle_cnt_q, cycle_cnt_d;
  logic                 timeout_q, timeout_d;

  logic [CNT_W-1:0]     pop_cnt;
  logic [NUM_CORES-1:0] done_hit;
  logic                 done_all;
  logic [CYC_W-1:0]     cyc_inc;

  core_popcount #(
    .N     (NUM_CORES),
    .CNT_W (CNT_W)
  ) u_popcount (
    .vec (core_en),
    .cnt (pop_cnt)
  );

`ifdef CORE_SYNC_TIMEOUT_EN
  localparam logic [CYC_W-1:0] TO_LIM = CYC_W'(TIMEOUT_CYC);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  // Completion looks at this cycle's done too, so the last done finishes the run without delay.
  assign done_hit = core_done & en_q;
  assign done_all = ((done_seen_q | done_hit) == en_q);
  assign cyc_inc  = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CYC_W'(1);

  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    done_seen_d  = done_seen_q;
    core_start_d = '0;
    busy_d       = busy_q;
    all_done_d   = 1'b0;
    start_err_d  = 1'b0;
    active_cnt_d = active_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    timeout_d    = timeout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (|core_en) begin
            en_d         = core_en;
            done_seen_d  = '0;
            active_cnt_d = pop_cnt;
            cycle_cnt_d  = '0;
            timeout_d    = 1'b0;
            core_start_d = core_en;
            busy_d       = 1'b1;
            state_d      = LAUNCH;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end

      LAUNCH: begin
        done_seen_d = done_seen_q | done_hit;
        cycle_cnt_d = cyc_inc;
        state_d     = RUN;
      end

      RUN: begin
        done_seen_d = done_seen_q | done_hit;
        cycle_cnt_d = cyc_inc;
        if (done_all) begin
          all_done_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = FINISH;
        end
`ifdef CORE_SYNC_TIMEOUT_EN
        else if (cyc_inc >= TO_LIM) begin
          // Abandon the stragglers but still close the run so the host is not left waiting.
          all_done_d = 1'b1;
          busy_d     = 1'b0;
          timeout_d  = 1'b1;
          state_d    = FINISH;
        end
`endif
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      en_q         <= '0;
      done_seen_q  <= '0;
      core_start_q <= '0;
      busy_q       <= 1'b0;
      all_done_q   <= 1'b0;
      start_err_q  <= 1'b0;
      active_cnt_q <= '0;
      cycle_cnt_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      done_seen_q  <= done_seen_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      all_done_q   <= all_done_d;
      start_err_q  <= start_err_d;
      active_cnt_q <= active_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign core_start = core_start_q;
  assign busy       = busy_q;
  assign all_done   = all_done_q;
  assign start_err  = start_err_q;
  assign active_cnt = active_cnt_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign timeout    = timeout_q;

endmodule
